// File: rtl/calc_pkg.sv
// Shared types and constants for the UART calculator controller:
// FSM states, ALU opcodes, ASCII codes and the operator decoder.
package calc_pkg;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    EXEC,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    SEND_CR,
    WAIT_CR,
    SEND_ERR,
    WAIT_ERR,
    ECHO_SEND,
    ECHO_WAIT
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_QM = 8'h3F;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_A  = 8'h41;

  typedef struct packed {
    logic       vld;
    logic [5:0] op;
  } op_dec_t;

  function automatic op_dec_t op_decode(
    input logic [7:0] ch
  );
    op_dec_t r;
    r.vld = 1'b1;
    r.op  = OP_ADD;
    unique case (ch)
      8'h2B:   r.op = OP_ADD;
      8'h2D:   r.op = OP_SUB;
      8'h26:   r.op = OP_AND;
      8'h7C:   r.op = OP_OR;
      8'h5E:   r.op = OP_XOR;
      8'h7E:   r.op = OP_NOR;
      8'h3E:   r.op = OP_SRA;
      8'h3C:   r.op = OP_SRL;
      default: r.vld = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] hex_char(
    input logic [3:0] n
  );
    if (n < 4'd10) return CH_0 + {4'h0, n};
    return CH_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/calc_dec_accum.sv
// Decimal accumulator: acc = acc*10 + digit, with a digit-seen flag
// and a look-ahead overflow flag for the digit currently presented.
module calc_dec_accum #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         dig_stb,
  input  logic [3:0]   dig,
  output logic [N-1:0] val,
  output logic         has_digit,
  output logic         overflow
);

  localparam int W = N + 4;
  localparam logic [W-1:0] MAX = {4'h0, {N{1'b1}}};
  localparam logic [W-1:0] TEN = {{N{1'b0}}, 4'd10};

  logic [W-1:0] acc_q, acc_d, nxt;
  logic         has_q, has_d;

  // acc never exceeds MAX, so W bits hold MAX*10+9 without loss
  always_comb begin
    nxt      = acc_q * TEN + {{N{1'b0}}, dig};
    overflow = nxt > MAX;
    acc_d    = acc_q;
    has_d    = has_q;
    if (clr) begin
      acc_d = '0;
      has_d = 1'b0;
    end else if (dig_stb) begin
      acc_d = nxt;
      has_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      has_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      has_q <= has_d;
    end
  end

  assign val       = acc_q[N-1:0];
  assign has_digit = has_q;

endmodule

// File: rtl/uart_calc_ctrl.sv
// UART calculator sequencer: parses "A op B CR", runs the ALU, replies
// in hex. Define UART_CALC_ECHO_EN to echo input bytes.
module uart_calc_ctrl
  import calc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         rx_done_tick,
  input  logic [7:0]   rx_dout,
  input  logic         tx_done_tick,
  output logic         tx_start,
  output logic [7:0]   tx_din,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_op,
  input  logic [N-1:0] alu_result,
  output logic [N-1:0] leds,
  output logic         err
);

  state_e         state_q, state_d, pst;
  logic [N-1:0]   alu_a_q, alu_a_d;
  logic [5:0]     alu_op_q, alu_op_d;
  logic [N-1:0]   res_q, res_d;
  logic           err_q, err_d;
  logic [7:0]     tx_din_q, tx_din_d;
  logic           in_vld, bad, clr;
  logic           dig_a, dig_b, is_dig, is_cr;
  logic [7:0]     in_byte;
  logic [N-1:0]   val_a, val_b;
  logic           has_a, has_b, ovf_a, ovf_b;
  op_dec_t        od;
`ifdef UART_CALC_ECHO_EN
  logic [7:0]     cur_q, cur_d, hold_q, hold_d;
  logic           hold_vld_q, hold_vld_d, drop;
  state_e         ret_q, ret_d;
`endif

  calc_dec_accum #(.N(N)) u_acc_a (
    .clk       (CLK),
    .rst_n     (RESET),
    .clr       (clr),
    .dig_stb   (dig_a),
    .dig       (in_byte[3:0]),
    .val       (val_a),
    .has_digit (has_a),
    .overflow  (ovf_a)
  );

  calc_dec_accum #(.N(N)) u_acc_b (
    .clk       (CLK),
    .rst_n     (RESET),
    .clr       (clr),
    .dig_stb   (dig_b),
    .dig       (in_byte[3:0]),
    .val       (val_b),
    .has_digit (has_b),
    .overflow  (ovf_b)
  );

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    err_d    = err_q;
    tx_din_d = tx_din_q;
    clr      = 1'b0;
    dig_a    = 1'b0;
    dig_b    = 1'b0;
    bad      = 1'b0;
    in_vld   = 1'b0;
    in_byte  = rx_dout;
    pst      = state_q;
`ifdef UART_CALC_ECHO_EN
    cur_d      = cur_q;
    ret_d      = ret_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    drop       = 1'b0;
`endif

    unique case (state_q)
      GET_A, GET_B: begin
`ifdef UART_CALC_ECHO_EN
        if (hold_vld_q || rx_done_tick) begin
          in_byte  = hold_vld_q ? hold_q : rx_dout;
          cur_d    = in_byte;
          ret_d    = state_q;
          tx_din_d = in_byte;
          state_d  = ECHO_SEND;
          if (hold_vld_q && rx_done_tick)
            hold_d = rx_dout;
          else
            hold_vld_d = 1'b0;
        end
`else
        in_vld = rx_done_tick;
`endif
      end
      EXEC: begin
        res_d    = alu_result;
        tx_din_d = hex_char(alu_result[7:4]);
        clr      = 1'b1;
        state_d  = SEND_HI;
      end
      SEND_HI: state_d = WAIT_HI;
      WAIT_HI: if (tx_done_tick) begin
        tx_din_d = hex_char(res_q[3:0]);
        state_d  = SEND_LO;
      end
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: if (tx_done_tick) begin
        tx_din_d = CH_CR;
        state_d  = SEND_CR;
      end
      SEND_CR: state_d = WAIT_CR;
      WAIT_CR: if (tx_done_tick) state_d = GET_A;
      SEND_ERR: state_d = WAIT_ERR;
      WAIT_ERR: if (tx_done_tick) begin
        tx_din_d = CH_CR;
        state_d  = SEND_CR;
      end
`ifdef UART_CALC_ECHO_EN
      ECHO_SEND: state_d = ECHO_WAIT;
      ECHO_WAIT: if (tx_done_tick) begin
        in_vld  = 1'b1;
        in_byte = cur_q;
        pst     = ret_q;
      end
`endif
      default: state_d = GET_A;
    endcase

`ifdef UART_CALC_ECHO_EN
    // one-entry buffer for bytes arriving while an echo is in flight
    if (rx_done_tick &&
        (state_q == ECHO_SEND || state_q == ECHO_WAIT)) begin
      if (hold_vld_q) begin
        drop = 1'b1;
      end else begin
        hold_d     = rx_dout;
        hold_vld_d = 1'b1;
      end
    end
`endif

    is_dig = (in_byte >= CH_0) && (in_byte <= CH_9);
    is_cr  = in_byte == CH_CR;
    od     = op_decode(in_byte);

    if (in_vld) begin
      state_d = pst;
      err_d   = 1'b0;
      if (pst == GET_A) begin
        if (is_dig && !ovf_a) begin
          dig_a = 1'b1;
        end else if (od.vld && has_a) begin
          alu_a_d  = val_a;
          alu_op_d = od.op;
          state_d  = GET_B;
        end else begin
          bad = 1'b1;
        end
      end else begin
        if (is_dig && !ovf_b)
          dig_b = 1'b1;
        else if (is_cr && has_b)
          state_d = EXEC;
        else
          bad = 1'b1;
      end
      if (bad) begin
        state_d  = SEND_ERR;
        tx_din_d = CH_QM;
        err_d    = 1'b1;
        clr      = 1'b1;
      end
`ifdef UART_CALC_ECHO_EN
      if (state_d == EXEC || state_d == SEND_ERR)
        hold_vld_d = 1'b0;
`endif
    end

`ifdef UART_CALC_ECHO_EN
    if (drop) err_d = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= GET_A;
      alu_a_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      tx_din_q <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      err_q    <= err_d;
      tx_din_q <= tx_din_d;
    end
  end

`ifdef UART_CALC_ECHO_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cur_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ret_q      <= GET_A;
    end else begin
      cur_q      <= cur_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ret_q      <= ret_d;
    end
  end
`endif

  assign tx_start = (state_q == SEND_HI)  || (state_q == SEND_LO) ||
                    (state_q == SEND_CR)  || (state_q == SEND_ERR) ||
                    (state_q == ECHO_SEND);
  assign tx_din   = tx_din_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = val_b;
  assign alu_op   = alu_op_q;
  assign leds     = res_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Scoreboard bench for uart_calc_ctrl: reference ALU, transmitter
// model, expected TX bytes queued at stimulus time.
module tb_uart_calc_ctrl;

  localparam int TX_LAT = 20;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_din;
  logic [7:0] alu_a, alu_b, alu_result, leds;
  logic [5:0] alu_op;
  logic       err;

  int         errs = 0;
  int         checks = 0;
  int         tx_cnt = 0;
  logic       tx_busy = 1'b0;
  logic [7:0] exp_leds;
  logic [7:0] sb[$];

  always #5 CLK = ~CLK;

  uart_calc_ctrl #(.N(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .leds         (leds),
    .err          (err)
  );

  function automatic logic [5:0] op_code(input byte c);
    case (c)
      "+":     return 6'b100000;
      "-":     return 6'b100010;
      "&":     return 6'b100100;
      "|":     return 6'b100101;
      "^":     return 6'b100110;
      "~":     return 6'b100111;
      ">":     return 6'b000011;
      "<":     return 6'b000010;
      default: return 6'b111111;
    endcase
  endfunction

  function automatic logic [7:0] ref_alu(
    input logic [5:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 8'($signed(a) >>> b[2:0]);
      6'b000010: return a >> b[2:0];
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // transmitter model: accepts tx_start, answers after TX_LAT cycles
  initial begin
    logic [7:0] b;
    int n;
    tx_done_tick = 1'b0;
    forever begin
      @(negedge CLK);
      while (RESET && tx_start) begin
        tx_cnt++;
        b = tx_din;
        if (sb.size() == 0)
          chk("tx_extra", 32'(tx_din), 32'(sb.size()));
        else
          chk("tx_byte", 32'(tx_din), 32'(sb.pop_front()));
        tx_busy = 1'b1;
        n = 0;
        while (n < TX_LAT && RESET) begin
          @(negedge CLK);
          n++;
        end
        if (RESET) begin
          chk("tx_hold", 32'(tx_din), 32'(b));
          tx_done_tick = 1'b1;
          @(negedge CLK);
          tx_done_tick = 1'b0;
        end
        tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_dout      = b;
    rx_done_tick = 1'b1;
    @(negedge CLK);
    rx_done_tick = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !tx_busy) break;
    end
    chk("idle", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic calc(input int a, input byte opc, input int b);
    string s;
    logic [5:0] op;
    logic [7:0] r;
    s  = $sformatf("%0d%c%0d", a, opc, b);
    op = op_code(opc);
    r  = ref_alu(op, 8'(a), 8'(b));
    sb.push_back(hexc(r[7:4]));
    sb.push_back(hexc(r[3:0]));
    sb.push_back(8'h0D);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(8'(s[i]));
      if (i == 0) chk("err_clr", 32'(err), 32'd0);
    end
    @(negedge CLK);
    rx_dout      = 8'h0D;
    rx_done_tick = 1'b1;
    @(negedge CLK);
    rx_done_tick = 1'b0;
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("alu_op", 32'(alu_op), 32'(op));
    @(negedge CLK);
    chk("tx_lat", 32'(tx_start), 32'd1);
    chk("leds_lat", 32'(leds), 32'(r));
    exp_leds = r;
    wait_idle();
    chk("calc_err", 32'(err), 32'd0);
    chk("calc_leds", 32'(leds), 32'(exp_leds));
  endtask

  task automatic bad(input string s);
    sb.push_back(8'h3F);
    sb.push_back(8'h0D);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    wait_idle();
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_leds", 32'(leds), 32'(exp_leds));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    RESET        = 1'b1;
    rx_done_tick = 1'b0;
    rx_dout      = 8'h00;
    exp_leds     = 8'h00;
    #3 RESET = 1'b0;
    #20;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_din", 32'(tx_din), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    calc(2, "-", 1);
    calc(200, "+", 100);
    calc(1, "-", 2);
    bad("256+1\r");
    calc(3, "&", 1);
    bad("+2\r");
    bad("5x2\r");
    bad("7+\r");
    bad("9+300\r");
    bad("4+5+\r");
    calc(9, "|", 6);
    calc(85, "^", 255);
    calc(15, "~", 240);
    calc(128, ">", 2);
    calc(255, "<", 4);
    calc(255, "+", 0);

    // reset while the low nibble is in flight
    base = tx_cnt;
    sb.push_back(8'h30);
    sb.push_back(8'h35);
    send_byte(8'h32);
    send_byte(8'h2B);
    send_byte(8'h33);
    send_byte(8'h0D);
    for (int i = 0; i < 200 && tx_cnt < base + 2; i++)
      @(negedge CLK);
    chk("rst_reach", 32'(tx_cnt), 32'(base + 2));
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("mid_tx_start", 32'(tx_start), 32'd0);
    chk("mid_leds", 32'(leds), 32'd0);
    chk("mid_tx_din", 32'(tx_din), 32'd0);
    chk("mid_sb", 32'(sb.size()), 32'd0);
    exp_leds = 8'h00;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    calc(2, "+", 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_calc_ctrl.md
# uart_calc_ctrl

Sequencing controller between the UART receiver/transmitter pair and the combinational ALU in the TP2 UART calculator. Parses an ASCII expression from the receiver (decimal operand, operator, decimal operand, CR), drives the ALU operands and opcode, and captures the result. It then sends the result back through the transmitter as two uppercase hex characters followed by CR, and mirrors the result on the LEDs.

## Interface
- `N`, 8: ALU operand/result width; operands above 2^N−1 are errors.
- `CLK` in 1: system clock, all state on rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `rx_done_tick` in 1: one-cycle strobe, `rx_dout` valid.
- `rx_dout` in 8: received byte.
- `tx_done_tick` in 1: one-cycle strobe, transmitter finished a byte.
- `tx_start` out 1: one-cycle strobe requesting transmission of `tx_din`.
- `tx_din` out 8: byte to transmit, held stable until `tx_done_tick`.
- `alu_a`, `alu_b` out N: operands to the ALU.
- `alu_op` out 6: ALU opcode.
- `alu_result` in N: combinational ALU result.
- `leds` out N: last valid result.
- `err` out 1: high after a rejected expression; cleared on the next accepted character.

## Operation
- Reset values:
  - all outputs 0;
  - state `GET_A`;
  - accumulators and holding register cleared.
- States:
  - `GET_A`: digits '0'–'9' accumulate `acc = acc*10 + d`. An operator char with ≥1 digit latched goes to `GET_B`.
  - `GET_B`: digits accumulate. CR (0x0D) with ≥1 digit goes to `EXEC`.
  - `EXEC`: one cycle. `alu_a`, `alu_b`, `alu_op` were already stable. Latch `alu_result` into `res` and `leds`. Go to `SEND_HI`.
  - `SEND_HI` / `SEND_LO` / `SEND_CR`: pulse `tx_start` for one cycle with the hex char of `res[7:4]`, `res[3:0]`, then 0x0D. Each waits in its `WAIT_*` state for `tx_done_tick`. After CR, return to `GET_A`.
  - `SEND_ERR`: pulse '?' (0x3F), wait, then CR, wait, then `GET_A`.
- Operator map:
  - '+' → 100000
  - '-' → 100010
  - '&' → 100100
  - '|' → 100101
  - '^' → 100110
  - '~' → 100111 (NOR)
  - '>' → 000011 (SRA)
  - '<' → 000010 (SRL)
- Errors go to `SEND_ERR` with `err`=1 and `leds` unchanged. Any of these is an error:
  - a character outside the expected class;
  - an operator or CR with no digits;
  - an accumulator exceeding 2^N−1. The accumulator is N+4 bits wide and the check is made after every digit.
- Hex chars: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- `rx_done_tick` during `EXEC`, `SEND_*` or `WAIT_*` is discarded.
- Arithmetic wraps modulo 2^N; no sign handling. For example, 1−2 gives 0xFF.

## Timing
- `alu_a` updates the cycle after the operator strobe.
- `alu_b` updates the cycle after each B digit.
- `alu_op` updates the cycle after the operator strobe.
- CR strobe at edge k:
  - `EXEC` at k+1;
  - `leds` valid at k+2;
  - first `tx_start` at k+2.
- A `tx_start` is never issued while a previous byte awaits `tx_done_tick`.
- `tx_done_tick` coinciding with `rx_done_tick`: the tx event is processed; the rx byte follows the discard rule above.
- `RESET` mid-transmission: `tx_start` drops immediately and the state returns to `GET_A`. The transmitter is reset by the same net.

## Configuration
- `UART_CALC_ECHO_EN`:
  - Defined: every byte accepted in `GET_A`/`GET_B` is echoed via `tx_start` before parsing continues.
  - A byte arriving during the echo wait is held in a one-entry holding register and parsed after `tx_done_tick`.
  - A second byte arriving while the holding register is full is dropped and sets `err`.
  - Undefined: no echo, no holding register; only result/error bytes are transmitted.

## Structure
- Package `calc_pkg` holds:
  - state enum;
  - ALU opcode constants;
  - ASCII constants (CR, '?', '0', 'A');
  - the char→opcode mapping function.
- Sub-module `calc_dec_accum` (N param) implements:
  - clear;
  - digit strobe;
  - multiply-by-10-plus-digit;
  - `has_digit` and `overflow` flags.
- It is instantiated twice, once for A and once for B.

## Test plan
- "2-1\r" → `alu_a`=2, `alu_b`=1, `alu_op`=100010; TX 0x30,0x31,0x0D; `leds`=0x01.
- "200+100\r" → wrap to 0x2C; TX 0x32,0x43,0x0D; `err`=0.
- "1-2\r" → TX 0x46,0x46,0x0D; `leds`=0xFF.
- "256+1\r" → TX 0x3F,0x0D; `err`=1; `leds` keeps its prior value; next "3&1\r" → TX "01\r" and `err`=0.
- "+2\r" → error response; "5x2\r" → error at 'x'.
- `RESET` low during `WAIT_LO` → `tx_start`=0, `leds`=0; a following "2+2\r" → TX "04\r".
